// File: rtl/mc_core_pkg.sv
// rtl/mc_core_pkg.sv - shared state, opcode/funct and ALU-operation definitions for mc_core
package mc_core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 32-entry register file, two read ports, one write port, r0 hardwired to zero
module mc_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [4:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle core sequencing FETCH/DECODE/EXEC/MEM/WB around mc_regfile
module mc_core
  import mc_core_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired
);

  state_e            state_q;
  alu_op_e           alu_op_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       retired_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              err_q;
  logic              halted_q;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic              rf_we;
  logic [4:0]        rf_waddr;

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm_ext = DATA_W'($signed(ir_q[15:0]));
  assign alu_b   = (opcode == OP_RTYPE) ? b_q : imm_ext;

  always_comb begin
    alu_y = a_q + alu_b;
    case (alu_op_q)
      ALU_ADD: alu_y = a_q + alu_b;
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SLT: alu_y = DATA_W'($signed(a_q) < $signed(alu_b));
      default: alu_y = a_q + alu_b;
    endcase
  end

  // Reset gates the request combinationally so an in-flight transfer is abandoned at once.
  assign mem_req   = !reset && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign mem_we    = (state_q == ST_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_q == ST_MEM) ? res_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata = b_q;

  assign rf_we    = (state_q == ST_WB);
  assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;

  mc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .raddr_a_i (rs),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (rt),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (res_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      alu_op_q  <= ALU_ADD;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata[31:0];
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q      <= rf_rdata_a;
          b_q      <= rf_rdata_b;
          alu_op_q <= ALU_ADD;
          state_q  <= ST_EXEC;
          case (opcode)
            OP_RTYPE: begin
              case (funct)
                FN_ADD: alu_op_q <= ALU_ADD;
                FN_SUB: alu_op_q <= ALU_SUB;
                FN_AND: alu_op_q <= ALU_AND;
                FN_OR:  alu_op_q <= ALU_OR;
                FN_SLT: alu_op_q <= ALU_SLT;
                default: begin
                  err_q    <= 1'b1;
                  halted_q <= 1'b1;
                  state_q  <= ST_HALT;
                end
              endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: ;
            OP_J: begin
              pc_q      <= ADDR_W'(ir_q[25:0]);
              retired_q <= retired_q + 32'd1;
              state_q   <= ST_FETCH;
            end
            OP_HALT: begin
              halted_q  <= 1'b1;
              retired_q <= retired_q + 32'd1;
              state_q   <= ST_HALT;
            end
            default: begin
              err_q    <= 1'b1;
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
          endcase
        end
        ST_EXEC: begin
          if (opcode == OP_BEQ) begin
            // pc_q already points past the branch, so the offset is relative to PC+1.
            if (a_q == b_q) begin
              pc_q <= pc_q + ADDR_W'($signed(ir_q[15:0]));
            end
            retired_q <= retired_q + 32'd1;
            state_q   <= ST_FETCH;
          end else begin
            res_q   <= alu_y;
            state_q <= ((opcode == OP_LW) || (opcode == OP_SW)) ? ST_MEM : ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_SW) begin
              retired_q <= retired_q + 32'd1;
              state_q   <= ST_FETCH;
            end else begin
              res_q   <= mem_rdata;
              state_q <= ST_WB;
            end
          end
        end
        ST_WB: begin
          retired_q <= retired_q + 32'd1;
          state_q   <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign halted  = halted_q;
  assign err     = err_q;
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/ALU/memory data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width of PC and memory address.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_req  output  1  memory access request, held until accepted.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-008 mem_addr  output  ADDR_W  word address; valid while mem_req.
REQ-009 mem_wdata  output  DATA_W  store data; valid while mem_req && mem_we.
REQ-010 mem_rdata  input  DATA_W  read data; sampled in the accept cycle.
REQ-011 mem_ready  input  1  accept; a transfer completes on a cycle with mem_req && mem_ready.
REQ-012 halted  output  1  core stopped (HALT instruction or illegal opcode).
REQ-013 err  output  1  sticky; set on an illegal opcode or funct.
REQ-014 pc  output  ADDR_W  current PC.
REQ-015 retired  output  32  count of completed instructions, wraps modulo 2^32.

Function
REQ-016 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: read at PC; on accept, IR <= mem_rdata[31:0] and PC <= PC+1 (word addressed, wraps modulo 2^ADDR_W); then go to DECODE.
REQ-018 DECODE: A <= reg[rs], B <= reg[rt]; opcode decode selects the next state.
REQ-019 R-type (op 000000) funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed); EXEC then WB to rd.
REQ-020 addi (001000): rt <= rs + signext(imm16) via EXEC, WB.
REQ-021 lw (100011): EXEC computes rs+signext(imm); MEM read; WB writes the value to rt.
REQ-022 sw (101011): EXEC computes the address; MEM writes B; return to FETCH with no WB.
REQ-023 beq (000100): in EXEC, if A==B then PC <= PC + signext(imm) (PC already incremented); next state FETCH.
REQ-024 j (000010): in DECODE, PC <= instr[ADDR_W-1:0] of the 26-bit field (zero-extended if ADDR_W>26); next state FETCH.
REQ-025 halt (111111): next state HALT; halted=1; remain in HALT until reset; mem_req=0.
REQ-026 Any other opcode or funct: err <= 1, next state HALT, no register or memory change.
REQ-027 The FSM SHALL hold FETCH/MEM with mem_req, mem_addr, mem_we and mem_wdata stable until accepted; wait states are unbounded.
REQ-028 Register r0 SHALL read as 0 at all times; writes to r0 SHALL be discarded.
REQ-029 Arithmetic SHALL be two's complement, DATA_W wide, with overflow wrapping silently; imm16 sign-extends to DATA_W; slt yields 1 or 0.
REQ-030 Latency with zero-wait memory: R-type/addi/sw 4 cycles, lw 5, beq 3, j 2 (FETCH, DECODE).
REQ-031 retired SHALL increment by 1 in the final state of each legal instruction; halt itself also counts.
REQ-032 mem_req SHALL be asserted only in FETCH and MEM.

Reset
REQ-033 On reset: state=FETCH, PC=RESET_PC, all 32 registers=0, IR=0, err=0, halted=0, retired=0, mem_req=0.
REQ-034 Reset asserted mid-transfer SHALL drop mem_req in the same cycle (asynchronous); the abandoned transfer has no architectural effect.

Structure
REQ-035 A shared package SHALL hold the state enum, the opcode/funct constants, and the ALU-operation enum.
REQ-036 The register file SHALL be one sub-module, mc_regfile (2 read ports, 1 write port, r0 forced to zero).

Verification
REQ-037 Program "addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt" with zero-wait memory -> r3=2, retired=4, halted=1 at cycle 14.
REQ-038 sw r1,(r0+0x10) then lw r4,(r0+0x10) with mem_ready low for 3 cycles per access -> mem_addr=0x10 stable while stalled; r4=r1.
REQ-039 beq r1,r1,+2 at PC=4 -> next fetch at address 7; beq with r1≠r2 -> next fetch at 5.
REQ-040 Opcode 010101 -> err=1, halted=1, no further mem_req, registers unchanged.
REQ-041 addi r0,r0,7 then add r5,r0,r0 -> r5=0; with DATA_W=64, add of 0x7FFF_FFFF_FFFF_FFFF+1 -> 0x8000_0000_0000_0000.
REQ-042 Reset asserted during a stalled MEM write -> mem_req low immediately; PC=RESET_PC; memory is not written.
